// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit for the MIPS core.
// Executes MULT, MULTU, DIV and DIVU. Multiply is radix-2 shift-add and
// divide is restoring, one iteration per enabled clock, WIDTH iterations.
// The result is written straight into the HI/LO register file during DONE.
//
// Ports:
//   clk             - system clock, rising edge
//   reset           - asynchronous active-high reset, forces IDLE
//   clk_enable      - global stall; when low all state holds
//   start           - operation request, sampled only in IDLE
//   op              - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op_a            - rs operand (multiplicand / dividend)
//   op_b            - rt operand (multiplier / divisor)
//   busy            - high in every state except IDLE
//   HI_result       - high product or remainder (registered)
//   LO_result       - low product or quotient (registered)
//   HI_write_enable - one-cycle write pulse in DONE
//   LO_write_enable - one-cycle write pulse in DONE, equal to HI_write_enable
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] HI_result,
    output logic [WIDTH-1:0] LO_result,
    output logic             HI_write_enable,
    output logic             LO_write_enable
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     opnd_r;

    logic                 is_div_s;
    logic                 sign_a_s;
    logic                 sign_b_s;
    logic                 neg_q_s;
    logic                 b_zero_s;
    logic                 last_iter_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       shifted_s;
    logic [WIDTH-1:0]     diff_s;
    logic                 ge_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     hi_fix_s;
    logic [WIDTH-1:0]     lo_fix_s;

    // Two's-complement negation of a single-width word.
    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a double-width word.
    function automatic logic [2*WIDTH-1:0] negate_dw(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand decode: op[1] selects divide, op[0]=0 means signed.
    assign is_div_s    = op_r[1];
    assign sign_a_s    = ~op_r[0] & a_r[WIDTH-1];
    assign sign_b_s    = ~op_r[0] & b_r[WIDTH-1];
    assign neg_q_s     = sign_a_s ^ sign_b_s;
    assign b_zero_s    = (b_r == {WIDTH{1'b0}});
    assign mag_a_s     = sign_a_s ? negate_w(a_r) : a_r;
    assign mag_b_s     = sign_b_s ? negate_w(b_r) : b_r;
    assign last_iter_s = (state_r == ST_CALC) && (cnt_r == CNT_LAST);

    // State register, held while the pipeline is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else if (clk_enable) begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_PREP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PREP: state_next_s = ST_CALC;
            ST_CALC: begin
                if (last_iter_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        busy            = 1'b1;
        HI_write_enable = 1'b0;
        LO_write_enable = 1'b0;
        case (state_r)
            ST_IDLE: busy = 1'b0;
            ST_PREP: busy = 1'b1;
            ST_CALC: busy = 1'b1;
            ST_DONE: begin
                HI_write_enable = 1'b1;
                LO_write_enable = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // One iteration of either algorithm. The accumulator holds
    // product-high:multiplier for multiply and remainder:quotient for divide.
    always_comb begin
        acc_next_s = acc_r;
        shifted_s  = acc_r[2*WIDTH-1:WIDTH-1];
        // The true difference is below the divisor whenever it is used,
        // so the low WIDTH bits of the modular subtraction are exact.
        diff_s     = shifted_s[WIDTH-1:0] - opnd_r;
        ge_s       = (shifted_s >= {1'b0, opnd_r});
        sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        if (is_div_s) begin
            if (ge_s) begin
                acc_next_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the final iteration's result. Divide by zero bypasses
    // it: quotient all ones, remainder is the original dividend bits.
    always_comb begin
        prod_s   = acc_next_s;
        hi_fix_s = acc_next_s[2*WIDTH-1:WIDTH];
        lo_fix_s = acc_next_s[WIDTH-1:0];
        if (is_div_s) begin
            if (b_zero_s) begin
                hi_fix_s = a_r;
                lo_fix_s = {WIDTH{1'b1}};
            end else begin
                lo_fix_s = neg_q_s ? negate_w(acc_next_s[WIDTH-1:0])
                                   : acc_next_s[WIDTH-1:0];
                hi_fix_s = sign_a_s ? negate_w(acc_next_s[2*WIDTH-1:WIDTH])
                                    : acc_next_s[2*WIDTH-1:WIDTH];
            end
        end else begin
            prod_s   = neg_q_s ? negate_dw(acc_next_s) : acc_next_s;
            hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
            lo_fix_s = prod_s[WIDTH-1:0];
        end
    end

    // Datapath registers: operand latch, preparation, iteration and the
    // result registers, which are loaded on the edge that enters DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r      <= 2'b00;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            HI_result <= {WIDTH{1'b0}};
            LO_result <= {WIDTH{1'b0}};
        end else if (clk_enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= op_a;
                        b_r  <= op_b;
                    end
                end
                ST_PREP: begin
                    acc_r  <= {{WIDTH{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
                    opnd_r <= is_div_s ? mag_b_s : mag_a_s;
                    cnt_r  <= {CW{1'b0}};
                end
                ST_CALC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_iter_s) begin
                        HI_result <= hi_fix_s;
                        LO_result <= lo_fix_s;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS core. Executes MULT, MULTU, DIV and DIVU.
- Drives the HI/LO register file directly: HI_result/LO_result connect to its HI_input/LO_input, and HI_write_enable/LO_write_enable connect to its write enables.
- Multi-cycle: radix-2 shift-add multiply, restoring divide. The busy output stalls MFHI/MFLO/MULT/DIV in the pipeline.

Parameters:
- WIDTH, 32, operand width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high. Forces IDLE immediately.
- clk_enable  input  1  global stall. When low, all state holds.
- start  input  1  request. Sampled only in IDLE with clk_enable=1.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with start.
- op_a  input  WIDTH  rs operand (multiplicand / dividend). Sampled with start.
- op_b  input  WIDTH  rt operand (multiplier / divisor). Sampled with start.
- busy  output  1  high in every state except IDLE.
- HI_result  output  WIDTH  high product or remainder.
- LO_result  output  WIDTH  low product or quotient.
- HI_write_enable  output  1  one-cycle write pulse, asserted only in DONE.
- LO_write_enable  output  1  one-cycle write pulse, asserted only in DONE. Always equal to HI_write_enable.

Behaviour:
- Clocking/reset:
  - One clock domain.
  - Reset is asynchronous active-high. It clears state to IDLE, iteration counter to 0, and all datapath registers to 0.
  - Outputs during/after reset: busy=0, both write enables=0, HI_result=0, LO_result=0.
  - Reset mid-operation abandons the operation; no write pulse is ever issued for it.
- clk_enable=0: FSM, counter and datapath hold. Outputs keep their current values, including an asserted write pulse in DONE. The register file is also gated, so no double write occurs.
- FSM states:
  - IDLE: start=1 at edge N → latch op, op_a, op_b → PREP.
  - PREP, 1 cycle: for signed ops take magnitudes of operands and record result signs. Unsigned ops pass operands through. Clear accumulator/remainder; counter=0 → CALC.
  - CALC, WIDTH cycles, one iteration per edge:
    - Multiply: conditional add of multiplicand into the upper half of a 2*WIDTH accumulator, then shift right.
    - Divide: shift remainder:quotient left, trial-subtract divisor, set quotient bit if non-negative.
    - Counter increments; on iteration WIDTH-1 → DONE.
  - DONE, 1 cycle: apply sign fix-up and present the result. Write enables=1, busy=1 → IDLE.
- Latency: start at edge N. Write enables are high between edges N+WIDTH+1 and N+WIDTH+2 (N+33..N+34 for WIDTH=32). The register file captures at edge N+34; busy falls at that edge.
- Start rules:
  - start is ignored when busy=1, including in DONE.
  - start is ignored when clk_enable=0.
  - Back-to-back ops: a new start is accepted on the first edge after DONE.
- Sign rules:
  - MULT: the product is negated when sign(a)≠sign(b).
  - DIV: the quotient is negated when sign(a)≠sign(b). The remainder takes the sign of the dividend, so it truncates toward zero.
- Boundary conditions:
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - MULT -2^31 * -2^31: HI=0x40000000, LO=0.
  - Divide by zero, DIV or DIVU with op_b=0: fixed result LO=all ones, HI=op_a unchanged (sign fix-up bypassed). Same latency; no exception.
- Outputs: HI_result/LO_result are registered. They hold the last completed result until the next DONE and are not cleared on return to IDLE.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF*0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Write enables high for exactly one cycle, 33 cycles after the start edge; busy high for 34 cycles.
- MULT 0xFFFFFFFD(-3)*7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000*0x80000000 → HI=0x40000000, LO=0.
- DIVU 100/7 → LO=0xE, HI=2. DIV 0xFFFFFFF9(-7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234. DIV 0xFFFFFFFB/0 → LO=0xFFFFFFFF, HI=0xFFFFFFFB.
- Start MULTU 3*5, then pulse start with DIVU 9/3 at cycle 10 → DIVU ignored. Result HI=0, LO=15. A new start on the first cycle after DONE is accepted.
- clk_enable low for 5 cycles during CALC → completion delayed by exactly 5 cycles, result unchanged. Assert reset mid-CALC (async, between edges) → busy=0 and both write enables 0 immediately, no write pulse ever for the aborted op; the next op completes correctly.
